ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  Execute stage plus EX/MEM pipeline register; sits directly downstream of the ID/EX register.
//  Consumes ID/EX operands, offset, Rs/Rt/Rd and control fields. Resolves RAW hazards by forwarding.
//  Computes the ALU result and registers result, store data, destination and MEM/WB controls for MEM.
// PARAMETERS
//  DW      32  datapath width
//  AW      5   register-index width
// PORTS
//  clk           in   1   rising-edge clock
//  rst           in   1   asynchronous, active-low reset
//  r1, r2        in   DW  ID/EX register-file operands (Rs, Rt)
//  offset        in   DW  sign-extended immediate from ID/EX
//  rs, rt, rd    in   AW  ID/EX register indices
//  ctrl_ex       in   7   [6] reg_dst (1:rd 0:rt), [5] alu_src (1:offset), [4] reserved, [3:0] alu_ctl
//  ctrl_m        in   4   [3] mem_read, [2] mem_write, [1] branch, [0] reserved; passed through
//  ctrl_wb       in   2   [1] reg_write, [0] mem_to_reg; passed through
//  wb_reg_write  in   1   MEM/WB reg_write
//  wb_rd         in   AW  MEM/WB destination index
//  wb_data       in   DW  MEM/WB write-back value
//  hold          in   1   1: freeze EX/MEM register (MEM-side stall)
//  flush         in   1   1: load a bubble into EX/MEM
//  alu_result    out  DW  registered ALU result
//  store_data    out  DW  registered forwarded r2
//  dest_reg      out  AW  registered write-back index
//  zero          out  1   registered (alu result == 0)
//  overflow      out  1   registered signed overflow of ADD/SUB
//  out_ctrl_m    out  4   registered ctrl_m
//  out_ctrl_wb   out  2   registered ctrl_wb
// BEHAVIOUR
//  Reset (rst=0, async): every output and internal register = 0.
//  Latency: 1 cycle. Inputs sampled at clk edge N appear on outputs after edge N.
//  Forward A (Rs), priority order:
//   1. EX/MEM: out_ctrl_wb[1] && dest_reg!=0 && dest_reg==rs -> alu_result
//   2. MEM/WB: wb_reg_write && wb_rd!=0 && wb_rd==rs -> wb_data
//   3. otherwise r1
//  Forward B (Rt): same rules against rt and r2. The forwarded B value is the store_data source.
//  Operand B to ALU = alu_src ? offset : forwarded B.
//  dest_reg source = reg_dst ? rd : rt.
//  alu_ctl: 0000 AND | 0001 OR | 0010 ADD | 0110 SUB | 0111 SLT (signed, result 0/1) | 1100 NOR | others -> 0.
//  Arithmetic: ADD/SUB wrap modulo 2^DW.
//  overflow=1 only for ADD/SUB when the operand signs make the result sign wrong. Otherwise 0.
//  Edge priority: flush > hold > load.
//   flush: out_ctrl_m=0, out_ctrl_wb=0, dest_reg=0; alu_result/store_data/zero/overflow unchanged.
//   hold: all registers keep their value. Forwarding still uses the held EX/MEM contents.
//   load: register all computed values.
//  Bubble input (ctrl_m=0, ctrl_wb=0) propagates as a bubble and never forwards.
//  Index 0 never forwards, even with reg_write set.
//  Reset mid-operation clears the pipeline immediately; the first edge after release is a normal load.
// STRUCTURE
//  pipeline_pkg holds the shared definitions:
//   - ALU_AND/OR/ADD/SUB/SLT/NOR codes
//   - ctrl_ex/ctrl_m/ctrl_wb bit-index constants
//   - fwd_sel_t enum {FWD_RF, FWD_EXMEM, FWD_MEMWB}
//  Sub-module alu: purely combinational (a, b, alu_ctl -> y, overflow).
//  Forwarding selects, the operand mux and the EX/MEM register are local to this block.
// TESTING
//  1. Reset: rst=0 while inputs are nonzero -> all outputs 0; release, ADD r1=5 r2=7 reg_dst=1 rd=3 -> alu_result=12, dest_reg=3.
//  2. EX/MEM forward: ADD writes $8=0x10, next instr rs=8 r1=0 ADD offset=4 alu_src=1 -> alu_result=0x14.
//  3. Double hazard: EX/MEM dest 9=1, MEM/WB wb_rd=9 wb_data=99, rs=9 -> EX/MEM wins, A=1.
//  4. $0: prior write to dest 0 with reg_write=1, rs=0 r1=0x55 -> A=0x55 (no forward).
//  5. Overflow/SLT: ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1; SLT -1 vs 1 -> 1, zero=0.
//  6. hold then flush: hold=1 for 2 cycles -> outputs frozen; flush=1 -> out_ctrl_wb=0, out_ctrl_m=0, dest_reg=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Definitions shared by the execute stage: ALU opcodes, control-field bit positions
// and the forwarding-select encoding.
package pipeline_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam int unsigned EX_REG_DST     = 6;
  localparam int unsigned EX_ALU_SRC     = 5;
  localparam int unsigned M_MEM_READ     = 3;
  localparam int unsigned M_MEM_WRITE    = 2;
  localparam int unsigned M_BRANCH       = 1;
  localparam int unsigned WB_REG_WRITE   = 1;
  localparam int unsigned WB_MEM_TO_REG  = 0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/ex_mem_stage_alu.sv
// Combinational ALU for the execute stage; overflow is reported only for ADD and SUB.
module alu
  import pipeline_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    alu_ctl,
  output logic [DW-1:0] y,
  output logic          overflow
);

  logic [DW-1:0] sum;
  logic [DW-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    y        = '0;
    overflow = 1'b0;
    case (alu_ctl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: begin
        y        = sum;
        overflow = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      ALU_SUB: begin
        y        = diff;
        overflow = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
      ALU_SLT: y = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding and the EX/MEM pipeline register.
module ex_mem_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] r1,
  input  logic [DW-1:0] r2,
  input  logic [DW-1:0] offset,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] rd,
  input  logic [6:0]    ctrl_ex,
  input  logic [3:0]    ctrl_m,
  input  logic [1:0]    ctrl_wb,
  input  logic          wb_reg_write,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          hold,
  input  logic          flush,
  output logic [DW-1:0] alu_result,
  output logic [DW-1:0] store_data,
  output logic [AW-1:0] dest_reg,
  output logic          zero,
  output logic          overflow,
  output logic [3:0]    out_ctrl_m,
  output logic [1:0]    out_ctrl_wb
);

  fwd_sel_t      sel_a, sel_b;
  logic [DW-1:0] fwd_a, fwd_b, op_b, alu_y;
  logic          alu_ovf;
  logic [AW-1:0] dest_next;
  logic          unused_reserved;

  assign unused_reserved = ctrl_ex[4];

  // EX/MEM is the younger producer, so it beats MEM/WB; index 0 never forwards.
  function automatic fwd_sel_t pick(input logic [AW-1:0] idx);
    if (out_ctrl_wb[WB_REG_WRITE] && dest_reg != '0 && dest_reg == idx)
      return FWD_EXMEM;
    else if (wb_reg_write && wb_rd != '0 && wb_rd == idx)
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    sel_a = pick(rs);
    sel_b = pick(rt);
    case (sel_a)
      FWD_EXMEM: fwd_a = alu_result;
      FWD_MEMWB: fwd_a = wb_data;
      default:   fwd_a = r1;
    endcase
    case (sel_b)
      FWD_EXMEM: fwd_b = alu_result;
      FWD_MEMWB: fwd_b = wb_data;
      default:   fwd_b = r2;
    endcase
    op_b      = ctrl_ex[EX_ALU_SRC] ? offset : fwd_b;
    dest_next = ctrl_ex[EX_REG_DST] ? rd : rt;
  end

  alu #(.DW(DW)) u_alu (
    .a        (fwd_a),
    .b        (op_b),
    .alu_ctl  (ctrl_ex[3:0]),
    .y        (alu_y),
    .overflow (alu_ovf)
  );

  // A flush only kills the control/destination fields; the data fields are don't-care in a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result  <= '0;
      store_data  <= '0;
      dest_reg    <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      out_ctrl_m  <= '0;
      out_ctrl_wb <= '0;
    end else if (flush) begin
      dest_reg    <= '0;
      out_ctrl_m  <= '0;
      out_ctrl_wb <= '0;
    end else if (!hold) begin
      alu_result  <= alu_y;
      store_data  <= fwd_b;
      dest_reg    <= dest_next;
      zero        <= (alu_y == '0);
      overflow    <= alu_ovf;
      out_ctrl_m  <= ctrl_m;
      out_ctrl_wb <= ctrl_wb;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Vector-table bench for ex_mem_stage with a queue of expected EX/MEM contents.
module tb_ex_mem_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] r1, r2, offset, wb_data;
  logic [4:0]  rs, rt, rd, wb_rd;
  logic [6:0]  ctrl_ex;
  logic [3:0]  ctrl_m;
  logic [1:0]  ctrl_wb;
  logic        wb_reg_write, hold, flush;
  logic [31:0] alu_result, store_data;
  logic [4:0]  dest_reg;
  logic        zero, overflow;
  logic [3:0]  out_ctrl_m;
  logic [1:0]  out_ctrl_wb;

  int errors = 0;
  int checks = 0;

  ex_mem_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .r1(r1), .r2(r2), .offset(offset),
    .rs(rs), .rt(rt), .rd(rd), .ctrl_ex(ctrl_ex), .ctrl_m(ctrl_m), .ctrl_wb(ctrl_wb),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .hold(hold), .flush(flush),
    .alu_result(alu_result), .store_data(store_data), .dest_reg(dest_reg),
    .zero(zero), .overflow(overflow), .out_ctrl_m(out_ctrl_m), .out_ctrl_wb(out_ctrl_wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r1, r2, off;
    logic [4:0]  rs, rt, rd;
    logic        rdst, asrc;
    logic [3:0]  ctl, cm;
    logic [1:0]  cwb;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        hold, flush;
    logic [31:0] e_alu, e_sd;
    logic [4:0]  e_dest;
    logic        e_z, e_o;
    logic [3:0]  e_cm;
    logic [1:0]  e_cwb;
  } vec_t;

  typedef struct {
    logic [31:0] alu, sd;
    logic [4:0]  dest;
    logic        z, o;
    logic [3:0]  cm;
    logic [1:0]  cwb;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  function automatic vec_t mk(
    input logic [31:0] a_r1, a_r2, a_off, input logic [4:0] a_rs, a_rt, a_rd,
    input logic a_rdst, a_asrc, input logic [3:0] a_ctl, a_cm, input logic [1:0] a_cwb,
    input logic a_wbw, input logic [4:0] a_wbrd, input logic [31:0] a_wbd,
    input logic a_hold, a_flush,
    input logic [31:0] x_alu, x_sd, input logic [4:0] x_dest, input logic x_z, x_o,
    input logic [3:0] x_cm, input logic [1:0] x_cwb);
    vec_t v;
    v.r1 = a_r1; v.r2 = a_r2; v.off = a_off; v.rs = a_rs; v.rt = a_rt; v.rd = a_rd;
    v.rdst = a_rdst; v.asrc = a_asrc; v.ctl = a_ctl; v.cm = a_cm; v.cwb = a_cwb;
    v.wbw = a_wbw; v.wbrd = a_wbrd; v.wbd = a_wbd; v.hold = a_hold; v.flush = a_flush;
    v.e_alu = x_alu; v.e_sd = x_sd; v.e_dest = x_dest; v.e_z = x_z; v.e_o = x_o;
    v.e_cm = x_cm; v.e_cwb = x_cwb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    r1 = v.r1; r2 = v.r2; offset = v.off; rs = v.rs; rt = v.rt; rd = v.rd;
    ctrl_ex = {v.rdst, v.asrc, 1'b0, v.ctl}; ctrl_m = v.cm; ctrl_wb = v.cwb;
    wb_reg_write = v.wbw; wb_rd = v.wbrd; wb_data = v.wbd; hold = v.hold; flush = v.flush;
    e.alu = v.e_alu; e.sd = v.e_sd; e.dest = v.e_dest; e.z = v.e_z; e.o = v.e_o;
    e.cm = v.e_cm; e.cwb = v.e_cwb;
    sbq.push_back(e);
  endtask

  task automatic check_pop(input int idx);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 (vector %0d)", idx);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("v%0d.alu_result", idx), alu_result, e.alu);
      chk($sformatf("v%0d.store_data", idx), store_data, e.sd);
      chk($sformatf("v%0d.dest_reg", idx), {27'd0, dest_reg}, {27'd0, e.dest});
      chk($sformatf("v%0d.zero", idx), {31'd0, zero}, {31'd0, e.z});
      chk($sformatf("v%0d.overflow", idx), {31'd0, overflow}, {31'd0, e.o});
      chk($sformatf("v%0d.out_ctrl_m", idx), {28'd0, out_ctrl_m}, {28'd0, e.cm});
      chk($sformatf("v%0d.out_ctrl_wb", idx), {30'd0, out_ctrl_wb}, {30'd0, e.cwb});
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".alu_result"}, alu_result, 32'd0);
    chk({tag, ".store_data"}, store_data, 32'd0);
    chk({tag, ".dest_reg"}, {27'd0, dest_reg}, 32'd0);
    chk({tag, ".zero"}, {31'd0, zero}, 32'd0);
    chk({tag, ".overflow"}, {31'd0, overflow}, 32'd0);
    chk({tag, ".out_ctrl_m"}, {28'd0, out_ctrl_m}, 32'd0);
    chk({tag, ".out_ctrl_wb"}, {30'd0, out_ctrl_wb}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        r1            r2            off           rs  rt  rd  rdst asrc ctl      cm       cwb  wbw wbrd wbd    hold flush | alu          sd            dest z  o  cm       cwb
    tbl.push_back(mk(32'd5,        32'd7,        32'd0,        1,  2,  3,  1, 0, ALU_ADD, 4'b0000, 2, 0, 0,  32'd0,  0, 0,  32'd12,       32'd7,        3,  0, 0, 4'b0000, 2));
    tbl.push_back(mk(32'h10,       32'd0,        32'd0,        4,  5,  8,  1, 0, ALU_ADD, 4'b0000, 2, 0, 0,  32'd0,  0, 0,  32'h10,       32'd0,        8,  0, 0, 4'b0000, 2));
    tbl.push_back(mk(32'd0,        32'h21,       32'd4,        8,  6,  10, 1, 1, ALU_ADD, 4'b0100, 0, 0, 0,  32'd0,  0, 0,  32'h14,       32'h21,       10, 0, 0, 4'b0100, 0));
    tbl.push_back(mk(32'hFFFFFFFF, 32'd2,        32'd0,        10, 11, 9,  1, 0, ALU_ADD, 4'b0000, 2, 0, 0,  32'd0,  0, 0,  32'd1,        32'd2,        9,  0, 0, 4'b0000, 2));
    tbl.push_back(mk(32'h77,       32'd0,        32'd0,        9,  9,  5,  0, 1, ALU_ADD, 4'b0000, 2, 1, 9,  32'd99, 0, 0,  32'd1,        32'd1,        9,  0, 0, 4'b0000, 2));
    tbl.push_back(mk(32'd0,        32'd5,        32'd0,        20, 21, 0,  0, 0, ALU_SUB, 4'b0000, 2, 1, 20, 32'd99, 0, 0,  32'd94,       32'd5,        21, 0, 0, 4'b0000, 2));
    tbl.push_back(mk(32'd1,        32'd1,        32'd0,        1,  2,  0,  1, 0, ALU_ADD, 4'b0000, 2, 1, 0,  32'hAA, 0, 0,  32'd2,        32'd1,        0,  0, 0, 4'b0000, 2));
    tbl.push_back(mk(32'h55,       32'h66,       32'd0,        0,  0,  13, 1, 0, ALU_OR,  4'b0000, 2, 1, 0,  32'hAA, 0, 0,  32'h77,       32'h66,       13, 0, 0, 4'b0000, 2));
    tbl.push_back(mk(32'h7FFFFFFF, 32'd1,        32'd0,        14, 15, 16, 1, 0, ALU_ADD, 4'b1000, 3, 0, 0,  32'd0,  0, 0,  32'h80000000, 32'd1,        16, 0, 1, 4'b1000, 3));
    tbl.push_back(mk(32'd1,        32'd1,        32'd0,        1,  2,  5,  1, 0, ALU_ADD, 4'b0000, 2, 0, 0,  32'd0,  0, 1,  32'h80000000, 32'd1,        0,  0, 1, 4'b0000, 0));
    tbl.push_back(mk(32'hFFFFFFFF, 32'd1,        32'd0,        17, 18, 19, 1, 0, ALU_SLT, 4'b0000, 2, 0, 0,  32'd0,  0, 0,  32'd1,        32'd1,        19, 0, 0, 4'b0000, 2));
    tbl.push_back(mk(32'd5,        32'd5,        32'd0,        1,  2,  20, 1, 0, ALU_SUB, 4'b0000, 2, 0, 0,  32'd0,  0, 0,  32'd0,        32'd5,        20, 1, 0, 4'b0000, 2));
    tbl.push_back(mk(32'h80000000, 32'd1,        32'd0,        1,  2,  21, 1, 0, ALU_SUB, 4'b0000, 2, 0, 0,  32'd0,  0, 0,  32'h7FFFFFFF, 32'd1,        21, 0, 1, 4'b0000, 2));
    tbl.push_back(mk(32'hF0F0,     32'hFF00,     32'd0,        1,  2,  22, 1, 0, ALU_AND, 4'b0000, 2, 0, 0,  32'd0,  0, 0,  32'hF000,     32'hFF00,     22, 0, 0, 4'b0000, 2));
    tbl.push_back(mk(32'd0,        32'd0,        32'd0,        1,  2,  23, 1, 0, ALU_NOR, 4'b0000, 2, 0, 0,  32'd0,  0, 0,  32'hFFFFFFFF, 32'd0,        23, 0, 0, 4'b0000, 2));
    tbl.push_back(mk(32'd5,        32'd6,        32'd0,        1,  2,  24, 1, 0, 4'b0011, 4'b0000, 2, 0, 0,  32'd0,  0, 0,  32'd0,        32'd6,        24, 1, 0, 4'b0000, 2));
    tbl.push_back(mk(32'd1,        32'hFFFFFFFF, 32'd0,        1,  2,  25, 1, 0, ALU_SLT, 4'b0000, 2, 0, 0,  32'd0,  0, 0,  32'd0,        32'hFFFFFFFF, 25, 1, 0, 4'b0000, 2));
    tbl.push_back(mk(32'd10,       32'h33,       32'hFFFFFFFE, 1,  2,  26, 1, 1, ALU_ADD, 4'b0000, 2, 0, 0,  32'd0,  0, 0,  32'd8,        32'h33,       26, 0, 0, 4'b0000, 2));
    tbl.push_back(mk(32'h100,      32'h200,      32'd0,        1,  2,  27, 1, 0, ALU_ADD, 4'b0100, 2, 0, 0,  32'd0,  0, 0,  32'h300,      32'h200,      27, 0, 0, 4'b0100, 2));
    tbl.push_back(mk(32'd9,        32'd9,        32'd0,        1,  2,  28, 1, 0, ALU_SUB, 4'b0000, 0, 0, 0,  32'd0,  1, 0,  32'h300,      32'h200,      27, 0, 0, 4'b0100, 2));
    tbl.push_back(mk(32'd3,        32'd4,        32'd0,        1,  2,  28, 1, 0, ALU_OR,  4'b1000, 3, 0, 0,  32'd0,  1, 0,  32'h300,      32'h200,      27, 0, 0, 4'b0100, 2));
    tbl.push_back(mk(32'd0,        32'd1,        32'd0,        27, 3,  29, 1, 0, ALU_ADD, 4'b0000, 2, 0, 0,  32'd0,  0, 0,  32'h301,      32'd1,        29, 0, 0, 4'b0000, 2));
    tbl.push_back(mk(32'd7,        32'd7,        32'd0,        1,  2,  30, 1, 0, ALU_ADD, 4'b1000, 2, 0, 0,  32'd0,  1, 1,  32'h301,      32'd1,        0,  0, 0, 4'b0000, 0));
    tbl.push_back(mk(32'h40,       32'd0,        32'd0,        29, 2,  31, 1, 0, ALU_ADD, 4'b0000, 2, 0, 0,  32'd0,  0, 0,  32'h40,       32'd0,        31, 0, 0, 4'b0000, 2));

    // Reset held low with busy inputs: everything must read zero.
    rst = 1'b0;
    r1 = 32'hDEAD; r2 = 32'hBEEF; offset = 32'h1234; rs = 5'd3; rt = 5'd4; rd = 5'd7;
    ctrl_ex = {1'b1, 1'b0, 1'b0, ALU_ADD}; ctrl_m = 4'b1100; ctrl_wb = 2'b11;
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'h99; hold = 1'b0; flush = 1'b0;
    #1;
    check_zero("reset_async");
    @(posedge clk); #1;
    check_zero("reset_held");

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      apply(tbl[i]);
      @(posedge clk); #1;
      check_pop(i);
    end

    // Mid-operation reset clears at once; the first edge after release forwards nothing stale.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("reset_mid");
    @(posedge clk); #1;
    check_zero("reset_mid_held");
    @(negedge clk);
    rst = 1'b1;
    apply(mk(32'd2, 32'd3, 32'd0, 31, 2, 4, 1, 0, ALU_ADD, 4'b0000, 2, 0, 0, 32'd0, 0, 0,
             32'd5, 32'd3, 4, 0, 0, 4'b0000, 2));
    @(posedge clk); #1;
    check_pop(100);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
